// File: rtl/vga_pkg.sv
// Shared 640x480@60 screen geometry, sync polarity and small decode helpers.
// Draw logic imports these constants instead of hard-coding screen sizes.
package vga_pkg;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int COORD_W = 10;
  localparam int FCNT_W  = 8;

  // Both syncs are active low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi_excl);
    return (v >= lo) && (v < hi_excl);
  endfunction

  function automatic logic sync_level(logic in_pulse);
    return in_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it, draw/animation logic reads it.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic              p_tick;
  coord_t            x;
  coord_t            y;
  logic              hsync;
  logic              vsync;
  logic              video_on;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (output p_tick, x, y, hsync, vsync, video_on, frame_start, frame_cnt);
  modport slave  (input  p_tick, x, y, hsync, vsync, video_on, frame_start, frame_cnt);
endinterface

// File: rtl/pixel_tick_div.sv
// Board-clock divider producing a one-clock pixel-enable strobe every CLK_DIV clocks.
module pixel_tick_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;

  // Next divider count; the strobe is registered from the next count so it is high while div_cnt == CLK_DIV-1.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = DIV_ZERO;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end
    p_tick_d = (div_cnt_d == DIV_LAST);
  end

  // Divider state and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= DIV_ZERO;
      p_tick_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_tick_q  <= p_tick_d;
    end
  end

  assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, h/v counters and registered decode
// outputs aligned with the coordinates they describe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam coord_t H_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic              p_tick_s;
  coord_t            x_q, x_d, y_q, y_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick_s)
  );

  // Raster counters advance only on pixel-enable edges.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick_s) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        if (y_q == V_LAST) begin
          y_d = 10'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Decode from the next coordinates so registered outputs line up with x/y;
  // holding until the first tick keeps video_on low at (0,0) after reset.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    if (p_tick_s) begin
      hsync_d       = sync_level(in_window(x_d, HS_BEG, HS_END));
      vsync_d       = sync_level(in_window(y_d, VS_BEG, VS_END));
      video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
      frame_start_d = (x_d == 10'd0) && (y_d == V_ACT);
      frame_cnt_d   = frame_start_d ? (frame_cnt_q + 8'd1) : frame_cnt_q;
    end else begin
      frame_cnt_d   = frame_cnt_q;
    end
  end

  // Counter and decode registers; reset drops any sync pulse in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga.p_tick      = p_tick_s;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-geometry instance
// (so whole frames and the 256-frame wrap fit in a short run), both against an arithmetic model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CD_B = 2;
  localparam int HA_B = 8, HFP_B = 1, HS_B = 2, HBP_B = 1;
  localparam int VA_B = 5, VFP_B = 1, VS_B = 2, VBP_B = 1;
  localparam int HT_B = HA_B + HFP_B + HS_B + HBP_B;
  localparam int VT_B = VA_B + VFP_B + VS_B + VBP_B;
  localparam int FRAME_CLK_B = HT_B * VT_B * CD_B;
  localparam logic [32:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  int     checks = 0;
  int     errors = 0;
  longint n = 0;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen dut_a (.clk(clk), .reset_n(reset_n), .vga(if_a));

  vga_timing_gen #(
    .CLK_DIV(CD_B), .H_ACTIVE(HA_B), .H_FP(HFP_B), .H_SYNC(HS_B), .H_BP(HBP_B),
    .V_ACTIVE(VA_B), .V_FP(VFP_B), .V_SYNC(VS_B), .V_BP(VBP_B)
  ) dut_b (.clk(clk), .reset_n(reset_n), .vga(if_b));

  always #5 clk = ~clk;

  // Rising edges seen since reset was last released.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n <= 0;
    else          n <= n + 1;
  end

  // Expected outputs after nn post-reset edges: pixel index = nn / cd, raster position from that.
  function automatic logic [32:0] model(longint nn, int cd, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp);
    int ht, vt, x, y, fc;
    longint t, pix, first;
    logic pt, hs, vs, von, fs;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    t   = nn / cd;
    pt  = ((nn % cd) == cd - 1);
    pix = t % (ht * vt);
    x   = int'(pix % ht);
    y   = int'(pix / ht);
    hs  = !((x >= ha + hfp) && (x < ha + hfp + hsw));
    vs  = !((y >= va + vfp) && (y < va + vfp + vsw));
    von = (t > 0) && (x < ha) && (y < va);
    fs  = (x == 0) && (y == va);
    first = longint'(va) * ht;
    fc  = (t >= first) ? int'(((t - first) / (ht * vt) + 1) % 256) : 0;
    return {pt, 10'(x), 10'(y), hs, vs, von, fs, 8'(fc)};
  endfunction

  function automatic logic [32:0] exp_a(longint nn);
    return model(nn, VGA_CLK_DIV, VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                 VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
  endfunction

  function automatic logic [32:0] exp_b(longint nn);
    return model(nn, CD_B, HA_B, HFP_B, HS_B, HBP_B, VA_B, VFP_B, VS_B, VBP_B);
  endfunction

  wire [32:0] obs_a = {if_a.p_tick, if_a.x, if_a.y, if_a.hsync, if_a.vsync,
                       if_a.video_on, if_a.frame_start, if_a.frame_cnt};
  wire [32:0] obs_b = {if_b.p_tick, if_b.x, if_b.y, if_b.hsync, if_b.vsync,
                       if_b.video_on, if_b.frame_start, if_b.frame_cnt};

  task automatic test_reset;
    int hold;
    hold = int'($urandom_range(2, 5));
    reset_n = 1'b0;
    repeat (hold) @(negedge clk);
    checks++; if (obs_a !== RESET_VEC) begin errors++; $display("FAIL reset_a: got %h want %h", obs_a, RESET_VEC); end
    checks++; if (obs_b !== RESET_VEC) begin errors++; $display("FAIL reset_b: got %h want %h", obs_b, RESET_VEC); end
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_a.p_tick !== (k == 3)) begin
        errors++; $display("FAIL first_tick edge %0d: got %b want %b", k, if_a.p_tick, (k == 3));
      end
      checks++;
      if (if_b.p_tick !== (k % 2 == 1)) begin
        errors++; $display("FAIL first_tick_b edge %0d: got %b want %b", k, if_b.p_tick, (k % 2 == 1));
      end
      checks++;
      if (k < 4) begin
        if ({if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.video_on} !== {10'd0, 10'd0, 3'b110}) begin
          errors++; $display("FAIL pre_tick edge %0d: x=%0d y=%0d hs=%b vs=%b von=%b want 0 0 1 1 0",
                             k, if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.video_on);
        end
      end else begin
        if ({if_a.x, if_a.video_on} !== {10'd1, 1'b1}) begin
          errors++; $display("FAIL post_tick: x=%0d von=%b want x=1 von=1", if_a.x, if_a.video_on);
        end
      end
    end
  endtask

  task automatic test_model_sweep(input int cycles);
    logic [32:0] ea, eb;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      ea = exp_a(n);
      eb = exp_b(n);
      checks++; if (obs_a !== ea) begin errors++; $display("FAIL sweep_a n=%0d: got %h want %h", n, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errors++; $display("FAIL sweep_b n=%0d: got %h want %h", n, obs_b, eb); end
    end
  endtask

  task automatic test_line;
    logic prev_hs;
    int   px, py;
    bit   seen_fall, seen_rise, seen_wrap;
    seen_fall = 0; seen_rise = 0; seen_wrap = 0;
    @(negedge clk);
    prev_hs = if_a.hsync; px = int'(if_a.x); py = int'(if_a.y);
    for (int c = 0; c < 3400 && !seen_wrap; c++) begin
      @(negedge clk);
      if (prev_hs && !if_a.hsync) begin
        seen_fall = 1; checks++;
        if (if_a.x !== 10'd656) begin errors++; $display("FAIL hsync_fall: x=%0d want 656", if_a.x); end
      end
      if (!prev_hs && if_a.hsync) begin
        seen_rise = 1; checks++;
        if (if_a.x !== 10'd752) begin errors++; $display("FAIL hsync_rise: x=%0d want 752", if_a.x); end
      end
      if (int'(if_a.x) != px && if_a.x == 10'd639) begin
        checks++; if (if_a.video_on !== 1'b1) begin errors++; $display("FAIL von_639: got %b want 1", if_a.video_on); end
      end
      if (int'(if_a.x) != px && if_a.x == 10'd640) begin
        checks++; if (if_a.video_on !== 1'b0) begin errors++; $display("FAIL von_640: got %b want 0", if_a.video_on); end
      end
      if (px == 799 && int'(if_a.x) != px) begin
        seen_wrap = 1; checks++;
        if (if_a.x !== 10'd0 || int'(if_a.y) != py + 1) begin
          errors++; $display("FAIL x_wrap: x=%0d y=%0d want x=0 y=%0d", if_a.x, if_a.y, py + 1);
        end
      end
      prev_hs = if_a.hsync; px = int'(if_a.x); py = int'(if_a.y);
    end
    checks++;
    if (!(seen_fall && seen_rise && seen_wrap)) begin
      errors++; $display("FAIL line_timeout: fall=%b rise=%b wrap=%b want all 1", seen_fall, seen_rise, seen_wrap);
    end
  endtask

  task automatic test_frame;
    int   rises, hs_falls, fs_width, prev_fcnt, prev_y, wraps;
    logic prev_hs, prev_fs, exp_vs;
    bit   done;
    rises = 0; hs_falls = 0; fs_width = 0; wraps = 0; done = 0;
    @(negedge clk);
    prev_hs = if_b.hsync; prev_fs = if_b.frame_start; prev_y = int'(if_b.y); prev_fcnt = int'(if_b.frame_cnt);
    for (int c = 0; c < 4 * FRAME_CLK_B && !done; c++) begin
      @(negedge clk);
      exp_vs = !((if_b.y >= 10'(VA_B + VFP_B)) && (if_b.y < 10'(VA_B + VFP_B + VS_B)));
      checks++; if (if_b.vsync !== exp_vs) begin errors++; $display("FAIL vsync y=%0d: got %b want %b", if_b.y, if_b.vsync, exp_vs); end
      if (prev_hs && !if_b.hsync) hs_falls++;
      if (!prev_fs && if_b.frame_start) begin
        checks++;
        if (if_b.x !== 10'd0 || if_b.y !== 10'(VA_B)) begin
          errors++; $display("FAIL fs_pos: x=%0d y=%0d want 0 %0d", if_b.x, if_b.y, VA_B);
        end
        checks++;
        if (if_b.frame_cnt !== 8'(prev_fcnt + 1)) begin
          errors++; $display("FAIL fcnt_inc: got %0d want %0d", if_b.frame_cnt, 8'(prev_fcnt + 1));
        end
        if (rises > 0) begin
          checks++; if (hs_falls != VT_B) begin errors++; $display("FAIL hs_per_frame: got %0d want %0d", hs_falls, VT_B); end
        end
        hs_falls = 0; rises++; fs_width = 1;
      end else if (prev_fs && if_b.frame_start && fs_width > 0) begin
        fs_width++;
      end else if (prev_fs && !if_b.frame_start && fs_width > 0) begin
        checks++; if (fs_width != CD_B) begin errors++; $display("FAIL fs_width: got %0d want %0d", fs_width, CD_B); end
        fs_width = 0;
        if (rises >= 3) done = 1;
      end
      if (prev_y == VT_B - 1 && int'(if_b.y) != prev_y) begin
        wraps++; checks++;
        if (if_b.y !== 10'd0 || if_b.x !== 10'd0) begin errors++; $display("FAIL y_wrap: x=%0d y=%0d want 0 0", if_b.x, if_b.y); end
      end
      prev_hs = if_b.hsync; prev_fs = if_b.frame_start; prev_y = int'(if_b.y); prev_fcnt = int'(if_b.frame_cnt);
    end
    checks++;
    if (!done || wraps < 2) begin errors++; $display("FAIL frame_timeout: done=%b wraps=%0d want 1 and >=2", done, wraps); end
  endtask

  task automatic test_video_on;
    int px, py;
    bit s1, s2, s3, s4;
    s1 = 0; s2 = 0; s3 = 0; s4 = 0;
    @(negedge clk);
    px = int'(if_b.x); py = int'(if_b.y);
    for (int c = 0; c < 3 * FRAME_CLK_B && !s4; c++) begin
      @(negedge clk);
      if (int'(if_b.x) != px || int'(if_b.y) != py) begin
        if (if_b.x == 10'(HA_B - 1) && if_b.y == 10'(VA_B - 1)) begin
          s1 = 1; checks++; if (if_b.video_on !== 1'b1) begin errors++; $display("FAIL von_last_active: got %b want 1", if_b.video_on); end
        end
        if (if_b.x == 10'(HA_B) && if_b.y == 10'(VA_B - 1)) begin
          s2 = 1; checks++; if (if_b.video_on !== 1'b0) begin errors++; $display("FAIL von_h_blank: got %b want 0", if_b.video_on); end
        end
        if (if_b.x == 10'd0 && if_b.y == 10'(VA_B)) begin
          s3 = 1; checks++; if (if_b.video_on !== 1'b0) begin errors++; $display("FAIL von_v_blank: got %b want 0", if_b.video_on); end
        end
        if (s3 && if_b.x == 10'd0 && if_b.y == 10'd0) begin
          s4 = 1; checks++;
          if ({if_b.video_on, if_b.hsync, if_b.vsync} !== 3'b111) begin
            errors++; $display("FAIL von_new_frame: von/hs/vs=%b%b%b want 111", if_b.video_on, if_b.hsync, if_b.vsync);
          end
        end
      end
      px = int'(if_b.x); py = int'(if_b.y);
    end
    checks++;
    if (!(s1 && s2 && s3 && s4)) begin errors++; $display("FAIL von_timeout: seen=%b%b%b%b want 1111", s1, s2, s3, s4); end
  endtask

  task automatic test_midframe_reset;
    bit found;
    found = 0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (if_a.x == 10'd300) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reset_wait: x=%0d want 300", if_a.x); end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (obs_a !== RESET_VEC) begin errors++; $display("FAIL async_reset_a: got %h want %h", obs_a, RESET_VEC); end
    checks++; if (obs_b !== RESET_VEC) begin errors++; $display("FAIL async_reset_b: got %h want %h", obs_b, RESET_VEC); end
    test_reset();
  endtask

  task automatic test_frame_cnt_wrap;
    int          rises;
    logic        prev_fs;
    logic [32:0] eb;
    rises = 0;
    test_reset();
    prev_fs = if_b.frame_start;
    for (int c = 0; c < 256 * FRAME_CLK_B + 400 && rises < 256; c++) begin
      @(negedge clk);
      eb = exp_b(n);
      checks++; if (obs_b !== eb) begin errors++; $display("FAIL wrap_sweep_b n=%0d: got %h want %h", n, obs_b, eb); end
      if (!prev_fs && if_b.frame_start) begin
        rises++;
        if (rises == 1) begin
          checks++; if (if_b.frame_cnt !== 8'd1) begin errors++; $display("FAIL fcnt_first: got %0d want 1", if_b.frame_cnt); end
        end
        if (rises == 256) begin
          checks++; if (if_b.frame_cnt !== 8'd0) begin errors++; $display("FAIL fcnt_wrap: got %0d want 0", if_b.frame_cnt); end
        end
      end
      prev_fs = if_b.frame_start;
    end
    checks++; if (rises != 256) begin errors++; $display("FAIL fcnt_timeout: frames=%0d want 256", rises); end
  endtask

  initial begin
    test_reset();
    test_model_sweep(int'($urandom_range(500, 1500)));
    test_line();
    test_frame();
    test_video_on();
    test_model_sweep(int'($urandom_range(300, 900)));
    test_midframe_reset();
    test_model_sweep(int'($urandom_range(200, 600)));
    test_frame_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
